// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: sizes, RRESP encodings and the R-channel beat record.
package axi_xbar_pkg;

   localparam int NUM_MASTERS = 3;
   localparam int ID_W        = 6;
   localparam int MID_W       = 2;
   localparam int TID_W       = 4;
   localparam int DATA_W      = 32;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_EXOKAY = 2'b01;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;
   localparam logic [1:0] RRESP_DECERR = 2'b11;

   typedef struct packed {
      logic [ID_W-1:0]   rid;
      logic [DATA_W-1:0] rdata;
      logic [1:0]        rresp;
      logic              rlast;
   } r_beat_t;

   // Master index carried in the top bits of a slave-side RID.
   function automatic logic [MID_W-1:0] rid_master(input logic [ID_W-1:0] rid);
      return rid[ID_W-1 -: MID_W];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word reads as zero while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // NOTE: storage has no reset; only the pointers and count are reset, and the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/read_data_router.sv
// Routes one slave's R channel into per-master FIFOs by RID master index; index 3 is dropped and flagged.
// Optional counters are built when READ_DATA_ROUTER_STATS_EN is defined.
module read_data_router #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = axi_xbar_pkg::DATA_W,
   parameter int ID_W       = axi_xbar_pkg::ID_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   m_axi_r_rid,
   input  logic [DATA_W-1:0] m_axi_r_rdata,
   input  logic [1:0]        m_axi_r_rresp,
   input  logic              m_axi_r_rlast,
   input  logic              m_axi_r_valid,
   output logic              m_axi_r_ready,
   output logic [ID_W-1:0]   s_to_m0_rid,
   output logic [DATA_W-1:0] s_to_m0_rdata,
   output logic [1:0]        s_to_m0_rresp,
   output logic              s_to_m0_rlast,
   output logic              s_to_m0_valid,
   input  logic              s_to_m0_ready,
   output logic [ID_W-1:0]   s_to_m1_rid,
   output logic [DATA_W-1:0] s_to_m1_rdata,
   output logic [1:0]        s_to_m1_rresp,
   output logic              s_to_m1_rlast,
   output logic              s_to_m1_valid,
   input  logic              s_to_m1_ready,
   output logic [ID_W-1:0]   s_to_m2_rid,
   output logic [DATA_W-1:0] s_to_m2_rdata,
   output logic [1:0]        s_to_m2_rresp,
   output logic              s_to_m2_rlast,
   output logic              s_to_m2_valid,
   input  logic              s_to_m2_ready,
`ifdef READ_DATA_ROUTER_STATS_EN
   output logic [15:0]       beat_cnt_m0,
   output logic [15:0]       beat_cnt_m1,
   output logic [15:0]       beat_cnt_m2,
   output logic [15:0]       burst_cnt_m0,
   output logic [15:0]       burst_cnt_m1,
   output logic [15:0]       burst_cnt_m2,
   output logic [15:0]       drop_cnt,
`endif
   input  logic              route_err_clr,
   output logic              route_err
);

   localparam int NM     = axi_xbar_pkg::NUM_MASTERS;
   localparam int WORD_W = ID_W + DATA_W + 3;

   logic [1:0]        w_dst;
   logic              w_drop;
   logic              w_accept;
   logic [NM-1:0]     w_full;
   logic [NM-1:0]     w_empty;
   logic [NM-1:0]     w_push;
   logic [NM-1:0]     w_m_ready;
   logic [WORD_W-1:0] w_wdata;
   logic [WORD_W-1:0] w_head [NM];
   logic              r_route_err;

   assign w_dst     = m_axi_r_rid[ID_W-1 -: 2];
   assign w_drop    = (w_dst == 2'd3);
   assign w_accept  = m_axi_r_valid && m_axi_r_ready;
   assign w_wdata   = {m_axi_r_rid, m_axi_r_rdata, m_axi_r_rresp, m_axi_r_rlast};
   assign w_m_ready = {s_to_m2_ready, s_to_m1_ready, s_to_m0_ready};

   // Ready looks only at registered full flags, so a same-cycle pop cannot make room.
   // NOTE: the default assignment first keeps this combinational block from inferring a latch.
   always_comb begin
      m_axi_r_ready = 1'b1;
      case (w_dst)
         2'd0:    m_axi_r_ready = !w_full[0];
         2'd1:    m_axi_r_ready = !w_full[1];
         2'd2:    m_axi_r_ready = !w_full[2];
         default: m_axi_r_ready = 1'b1;
      endcase
   end

   for (genvar n = 0; n < NM; n++) begin : g_fifo
      assign w_push[n] = w_accept && (w_dst == 2'(n));

      sync_fifo #(
         .WIDTH (WORD_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_push[n]),
         .i_wdata (w_wdata),
         .i_pop   (w_m_ready[n]),
         .o_full  (w_full[n]),
         .o_empty (w_empty[n]),
         .o_head  (w_head[n])
      );
   end

   assign {s_to_m0_rid, s_to_m0_rdata, s_to_m0_rresp, s_to_m0_rlast} = w_head[0];
   assign {s_to_m1_rid, s_to_m1_rdata, s_to_m1_rresp, s_to_m1_rlast} = w_head[1];
   assign {s_to_m2_rid, s_to_m2_rdata, s_to_m2_rresp, s_to_m2_rlast} = w_head[2];
   assign s_to_m0_valid = !w_empty[0];
   assign s_to_m1_valid = !w_empty[1];
   assign s_to_m2_valid = !w_empty[2];

   // A new misrouted beat outranks a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_route_err <= 1'b0;
      else if (w_accept && w_drop) r_route_err <= 1'b1;
      else if (route_err_clr)      r_route_err <= 1'b0;
   end

   assign route_err = r_route_err;

`ifdef READ_DATA_ROUTER_STATS_EN
   logic [15:0] r_beat_cnt  [NM];
   logic [15:0] r_burst_cnt [NM];
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NM; n++) begin
            r_beat_cnt[n]  <= '0;
            r_burst_cnt[n] <= '0;
         end
         r_drop_cnt <= '0;
      end else begin
         for (int n = 0; n < NM; n++) begin
            if (w_push[n])                      r_beat_cnt[n]  <= r_beat_cnt[n] + 16'd1;
            else if (route_err_clr)             r_beat_cnt[n]  <= '0;
            if (w_push[n] && m_axi_r_rlast)     r_burst_cnt[n] <= r_burst_cnt[n] + 16'd1;
            else if (route_err_clr)             r_burst_cnt[n] <= '0;
         end
         if (w_accept && w_drop)                r_drop_cnt <= r_drop_cnt + 16'd1;
         else if (route_err_clr)                r_drop_cnt <= '0;
      end
   end

   assign beat_cnt_m0  = r_beat_cnt[0];
   assign beat_cnt_m1  = r_beat_cnt[1];
   assign beat_cnt_m2  = r_beat_cnt[2];
   assign burst_cnt_m0 = r_burst_cnt[0];
   assign burst_cnt_m1 = r_burst_cnt[1];
   assign burst_cnt_m2 = r_burst_cnt[2];
   assign drop_cnt     = r_drop_cnt;
`endif

endmodule

// File: tb/tb_read_data_router.sv
// Directed bench for read_data_router: queue-based reference model checked every cycle plus literal spot checks.
module tb_read_data_router;
   import axi_xbar_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  m_axi_r_rid;
   logic [31:0] m_axi_r_rdata;
   logic [1:0]  m_axi_r_rresp;
   logic        m_axi_r_rlast;
   logic        m_axi_r_valid;
   logic        m_axi_r_ready;
   logic [5:0]  s_to_m0_rid, s_to_m1_rid, s_to_m2_rid;
   logic [31:0] s_to_m0_rdata, s_to_m1_rdata, s_to_m2_rdata;
   logic [1:0]  s_to_m0_rresp, s_to_m1_rresp, s_to_m2_rresp;
   logic        s_to_m0_rlast, s_to_m1_rlast, s_to_m2_rlast;
   logic        s_to_m0_valid, s_to_m1_valid, s_to_m2_valid;
   logic        s_to_m0_ready, s_to_m1_ready, s_to_m2_ready;
   logic        route_err_clr;
   logic        route_err;
`ifdef READ_DATA_ROUTER_STATS_EN
   logic [15:0] beat_cnt_m0, beat_cnt_m1, beat_cnt_m2;
   logic [15:0] burst_cnt_m0, burst_cnt_m1, burst_cnt_m2;
   logic [15:0] drop_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   read_data_router #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ID_W(6)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m_axi_r_rid   (m_axi_r_rid),
      .m_axi_r_rdata (m_axi_r_rdata),
      .m_axi_r_rresp (m_axi_r_rresp),
      .m_axi_r_rlast (m_axi_r_rlast),
      .m_axi_r_valid (m_axi_r_valid),
      .m_axi_r_ready (m_axi_r_ready),
      .s_to_m0_rid   (s_to_m0_rid),
      .s_to_m0_rdata (s_to_m0_rdata),
      .s_to_m0_rresp (s_to_m0_rresp),
      .s_to_m0_rlast (s_to_m0_rlast),
      .s_to_m0_valid (s_to_m0_valid),
      .s_to_m0_ready (s_to_m0_ready),
      .s_to_m1_rid   (s_to_m1_rid),
      .s_to_m1_rdata (s_to_m1_rdata),
      .s_to_m1_rresp (s_to_m1_rresp),
      .s_to_m1_rlast (s_to_m1_rlast),
      .s_to_m1_valid (s_to_m1_valid),
      .s_to_m1_ready (s_to_m1_ready),
      .s_to_m2_rid   (s_to_m2_rid),
      .s_to_m2_rdata (s_to_m2_rdata),
      .s_to_m2_rresp (s_to_m2_rresp),
      .s_to_m2_rlast (s_to_m2_rlast),
      .s_to_m2_valid (s_to_m2_valid),
      .s_to_m2_ready (s_to_m2_ready),
`ifdef READ_DATA_ROUTER_STATS_EN
      .beat_cnt_m0   (beat_cnt_m0),
      .beat_cnt_m1   (beat_cnt_m1),
      .beat_cnt_m2   (beat_cnt_m2),
      .burst_cnt_m0  (burst_cnt_m0),
      .burst_cnt_m1  (burst_cnt_m1),
      .burst_cnt_m2  (burst_cnt_m2),
      .drop_cnt      (drop_cnt),
`endif
      .route_err_clr (route_err_clr),
      .route_err     (route_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   r_beat_t    q [3][$];
   bit         m_err;
   logic [15:0] m_beat [3];
   logic [15:0] m_burst [3];
   logic [15:0] m_drop;

   function automatic bit exp_ready();
      int d = int'(rid_master(m_axi_r_rid));
      if (d == 3) return 1'b1;
      return q[d].size() < DEPTH;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            m_beat[i]  = '0;
            m_burst[i] = '0;
         end
         m_err  = 1'b0;
         m_drop = '0;
      end else begin
         bit      acc;
         int      d;
         bit [2:0] rdy;
         r_beat_t b;
         acc = m_axi_r_valid && exp_ready();
         d   = int'(rid_master(m_axi_r_rid));
         rdy = {s_to_m2_ready, s_to_m1_ready, s_to_m0_ready};
         b   = '{rid: m_axi_r_rid, rdata: m_axi_r_rdata, rresp: m_axi_r_rresp, rlast: m_axi_r_rlast};
         for (int i = 0; i < 3; i++) begin
            if (q[i].size() > 0 && rdy[i]) void'(q[i].pop_front());
            if (acc && d == i) begin
               m_beat[i]++;
               if (b.rlast) m_burst[i]++;
            end else if (route_err_clr) begin
               m_beat[i] = '0;
            end
            if (!(acc && d == i && b.rlast) && route_err_clr) m_burst[i] = '0;
         end
         if (acc && d < 3) q[d].push_back(b);
         if (acc && d == 3) begin
            m_err = 1'b1;
            m_drop++;
         end else if (route_err_clr) begin
            m_err  = 1'b0;
            m_drop = '0;
         end
      end
   end

   r_beat_t got_head  [3];
   logic    got_valid [3];
   assign got_head[0]  = {s_to_m0_rid, s_to_m0_rdata, s_to_m0_rresp, s_to_m0_rlast};
   assign got_head[1]  = {s_to_m1_rid, s_to_m1_rdata, s_to_m1_rresp, s_to_m1_rlast};
   assign got_head[2]  = {s_to_m2_rid, s_to_m2_rdata, s_to_m2_rresp, s_to_m2_rlast};
   assign got_valid[0] = s_to_m0_valid;
   assign got_valid[1] = s_to_m1_valid;
   assign got_valid[2] = s_to_m2_valid;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_axi_r_ready", 64'(m_axi_r_ready), 64'(exp_ready()));
         check("route_err", 64'(route_err), 64'(m_err));
         for (int i = 0; i < 3; i++) begin
            check($sformatf("m%0d_valid", i), 64'(got_valid[i]), 64'(q[i].size() != 0));
            if (q[i].size() != 0)
               check($sformatf("m%0d_head", i), 64'(got_head[i]), 64'(q[i][0]));
         end
`ifdef READ_DATA_ROUTER_STATS_EN
         check("beat_cnt_m0", 64'(beat_cnt_m0), 64'(m_beat[0]));
         check("beat_cnt_m1", 64'(beat_cnt_m1), 64'(m_beat[1]));
         check("beat_cnt_m2", 64'(beat_cnt_m2), 64'(m_beat[2]));
         check("burst_cnt_m0", 64'(burst_cnt_m0), 64'(m_burst[0]));
         check("burst_cnt_m1", 64'(burst_cnt_m1), 64'(m_burst[1]));
         check("burst_cnt_m2", 64'(burst_cnt_m2), 64'(m_burst[2]));
         check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] rid, input logic [31:0] data, input logic last);
      m_axi_r_rid   = rid;
      m_axi_r_rdata = data;
      m_axi_r_rresp = (rid[5:4] == 2'd3) ? RRESP_DECERR : RRESP_OKAY;
      m_axi_r_rlast = last;
      m_axi_r_valid = 1'b1;
   endtask

   task automatic idle();
      m_axi_r_valid = 1'b0;
   endtask

   task automatic send(input logic [5:0] rid, input logic [31:0] data, input logic last);
      int n = 0;
      drive(rid, data, last);
      #1;
      while (!m_axi_r_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) check("send_timeout", 64'(0), 64'(1));
      tick();
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      m_axi_r_rid = '0; m_axi_r_rdata = '0; m_axi_r_rresp = '0;
      m_axi_r_rlast = 1'b0; m_axi_r_valid = 1'b0;
      s_to_m0_ready = 1'b0; s_to_m1_ready = 1'b0; s_to_m2_ready = 1'b0;
      route_err_clr = 1'b0;
      #23 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_m0_valid", 64'(s_to_m0_valid), 64'(0));
      check("rst_m1_valid", 64'(s_to_m1_valid), 64'(0));
      check("rst_m2_valid", 64'(s_to_m2_valid), 64'(0));
      check("rst_m0_payload", 64'(got_head[0]), 64'(0));
      check("rst_m1_payload", 64'(got_head[1]), 64'(0));
      check("rst_m2_payload", 64'(got_head[2]), 64'(0));
      check("rst_route_err", 64'(route_err), 64'(0));
      check("rst_ready", 64'(m_axi_r_ready), 64'(1));
      cmp_en = 1'b1;
      tick();

      // Single beat to master 0
      send(6'h05, 32'hA5A5_0001, 1'b1);
      #1;
      check("t1_m0_valid", 64'(s_to_m0_valid), 64'(1));
      check("t1_m0_rid", 64'(s_to_m0_rid), 64'h05);
      check("t1_m0_rdata", 64'(s_to_m0_rdata), 64'hA5A5_0001);
      check("t1_m0_rlast", 64'(s_to_m0_rlast), 64'(1));
      check("t1_m1_valid", 64'(s_to_m1_valid), 64'(0));
      check("t1_m2_valid", 64'(s_to_m2_valid), 64'(0));
      s_to_m0_ready = 1'b1;
      tick();
      s_to_m0_ready = 1'b0;
      #1 check("t1_m0_popped", 64'(s_to_m0_valid), 64'(0));

      // Burst to master 1 fills its FIFO; full refuses even while being popped
      for (int i = 0; i < 4; i++) begin
         drive(6'h13, 32'h1300_0000 + 32'(i), 1'(i == 3));
         #1 check("t2_ready_fill", 64'(m_axi_r_ready), 64'(1));
         tick();
      end
      drive(6'h13, 32'h1300_0004, 1'b0);
      #1 check("t2_ready_full", 64'(m_axi_r_ready), 64'(0));
      s_to_m1_ready = 1'b1;
      tick();
      #1;
      check("t2_ready_back", 64'(m_axi_r_ready), 64'(1));
      check("t2_head_after_pop", 64'(s_to_m1_rdata), 64'h1300_0001);
      tick();
      idle();
      repeat (6) tick();
      s_to_m1_ready = 1'b0;

      // Full FIFO0 does not block master 2
      for (int i = 0; i < 4; i++) begin
         drive(6'h01, 32'h0100_0000 + 32'(i), 1'b0);
         tick();
      end
      s_to_m2_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(6'h21, 32'h2100_0000 + 32'(i), 1'(i == 5));
         #1 check("t3_m2_full_rate", 64'(m_axi_r_ready), 64'(1));
         tick();
      end
      drive(6'h02, 32'h0200_0000, 1'b1);
      #1 check("t3_m0_blocked", 64'(m_axi_r_ready), 64'(0));
      check("t3_m0_head", 64'(s_to_m0_rdata), 64'h0100_0000);
      idle();
      tick();
      s_to_m0_ready = 1'b1;
      repeat (5) tick();
      s_to_m0_ready = 1'b0;
      s_to_m2_ready = 1'b0;

      // Invalid destination and sticky error
      send(6'h3A, 32'hDEAD_BEEF, 1'b1);
      #1;
      check("t4_err_set", 64'(route_err), 64'(1));
      check("t4_no_valid", 64'({s_to_m0_valid, s_to_m1_valid, s_to_m2_valid}), 64'(0));
      route_err_clr = 1'b1;
      tick();
      route_err_clr = 1'b0;
      #1 check("t4_err_clr", 64'(route_err), 64'(0));
      drive(6'h31, 32'hDEAD_0002, 1'b0);
      route_err_clr = 1'b1;
      tick();
      idle();
      route_err_clr = 1'b0;
      #1 check("t4_set_wins", 64'(route_err), 64'(1));
      route_err_clr = 1'b1;
      tick();
      route_err_clr = 1'b0;

      // One entry held, push and pop together for 8 cycles
      send(6'h12, 32'h5000_0000, 1'b0);
      s_to_m1_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(6'h12, 32'h5000_0000 + 32'(i), 1'(i == 8));
         #1;
         check("t5_valid_held", 64'(s_to_m1_valid), 64'(1));
         check("t5_head_order", 64'(s_to_m1_rdata), 64'h5000_0000 + 64'(i - 1));
         tick();
      end
      idle();
      #1 check("t5_last_head", 64'(s_to_m1_rdata), 64'h5000_0008);
      tick();
      s_to_m1_ready = 1'b0;
      #1 check("t5_drained", 64'(s_to_m1_valid), 64'(0));

      // Reset mid-burst
      send(6'h03, 32'h6000_0000, 1'b0);
      send(6'h14, 32'h6000_0001, 1'b0);
      send(6'h24, 32'h6000_0002, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("t6_valid_drop", 64'({s_to_m0_valid, s_to_m1_valid, s_to_m2_valid}), 64'(0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("t6_empty", 64'({s_to_m0_valid, s_to_m1_valid, s_to_m2_valid}), 64'(0));
      send(6'h25, 32'hCAFE_0001, 1'b1);
      #1;
      check("t6_m2_valid", 64'(s_to_m2_valid), 64'(1));
      check("t6_m2_rdata", 64'(s_to_m2_rdata), 64'hCAFE_0001);
      check("t6_m01_idle", 64'({s_to_m0_valid, s_to_m1_valid}), 64'(0));
      s_to_m2_ready = 1'b1;
      repeat (3) tick();

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/read_data_router.md
Name: read_data_router

Overview:
- Slave-side counterpart of the master-side R-channel merge.
- Takes one slave's AXI read-data channel and decodes RID[5:4] to find the originating master (0..2).
- Pushes each beat into that master's dedicated FIFO. The FIFO outputs feed the per-master read-data arbiters as sN_to_m_axi_r_*.
- One instance per slave in the crossbar.

Parameters:
- FIFO_DEPTH, 4, entries per master FIFO; power of two, min 2.
- DATA_W, 32, RDATA width.
- ID_W, 6, slave-side RID width; [ID_W-1:ID_W-2] is the master index, [ID_W-3:0] is the transaction id.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_axi_r_rid  in  ID_W  slave RID
- m_axi_r_rdata  in  DATA_W  slave RDATA
- m_axi_r_rresp  in  2  slave RRESP
- m_axi_r_rlast  in  1  slave RLAST
- m_axi_r_valid  in  1  slave RVALID
- m_axi_r_ready  out  1  RREADY to slave
- sK_to_mN_rid  out  ID_W  per master N=0..2, full RID passed through
- sK_to_mN_rdata  out  DATA_W  per master
- sK_to_mN_rresp  out  2  per master
- sK_to_mN_rlast  out  1  per master
- sK_to_mN_valid  out  1  per master; FIFO not empty
- sK_to_mN_ready  in  1  per master, from that master's arbiter
- route_err  out  1  sticky; set when a beat arrives with master index 3
- route_err_clr  in  1  synchronous clear of route_err

Behaviour:
- Reset: all FIFOs empty, all sK_to_mN_valid=0, route_err=0, payload outputs 0.
- m_axi_r_ready is asserted in either case:
  - dst = RID[5:4] is 0..2 and FIFO[dst] is not full;
  - dst = 3, so the beat will be dropped.
- m_axi_r_ready depends only on the registered full flags, so there is no combinational path from sK_to_mN_ready. A FIFO that is full on this cycle refuses the beat even if it is popped on the same cycle.
- Accept: m_axi_r_valid && m_axi_r_ready. The beat is written to FIFO[dst] with rid/rdata/rresp/rlast unchanged.
- Latency: a beat accepted at edge T appears on sK_to_mN_* with valid=1 after edge T; there is no bypass path.
- Pop: sK_to_mN_valid && sK_to_mN_ready advances the read pointer. Outputs are driven straight from the head entry. Payload is held stable while valid && !ready.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance. This also applies when the FIFO holds exactly one entry; the new head appears after that edge.
- Full/empty: count ranges 0..FIFO_DEPTH with width $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - A push when full is impossible, because ready is gated.
  - A pop when empty is ignored, because valid is gated.
- Invalid destination (dst=3):
  - The beat is accepted and discarded, so a misrouted slave cannot hang.
  - route_err is set on the cycle after acceptance.
  - If route_err_clr and a new error occur on the same cycle, set wins.
- Ordering: beats for the same master leave in acceptance order. Beats for different masters are independent; a full FIFO[a] never blocks beats destined for b.
- No burst tracking and no state machine beyond the per-FIFO pointers. Interleaving is allowed; RID carries the routing.
- Reset mid-burst: all queued beats are lost and valids drop asynchronously. Upstream address-side tables must be reset together.

Optional Feature:
- Macro: READ_DATA_ROUTER_STATS_EN.
- When defined:
  - Adds outputs beat_cnt_mN[15:0] (N=0..2), counting pushes into FIFO N.
  - Adds outputs burst_cnt_mN[15:0], counting pushed beats with rlast=1.
  - Adds output drop_cnt[15:0], counting dst=3 beats.
  - All counters reset to 0, wrap at 16'hFFFF→0, and are cleared by route_err_clr (increment wins on the same cycle).
- When undefined: none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- Shared package axi_xbar_pkg:
  - NUM_MASTERS=3, ID_W=6, MID_W=2, TID_W=4, DATA_W=32.
  - RRESP encodings (OKAY=2'b00, DECERR=2'b11).
  - Typedef r_beat_t {rid, rdata, rresp, rlast}.
- Sub-module: sync_fifo (param WIDTH, DEPTH; push/pop/full/empty/count/head). It is instantiated three times with WIDTH = ID_W+DATA_W+3.

Test Plan:
- Reset, then one beat RID=6'h05, rdata=32'hA5A5_0001, rlast=1 → next cycle s_to_m0_valid=1 with the same fields; m1/m2 valid stay 0.
- 4-beat burst RID=6'h13 (master 1, tid 3) with m1_ready=0 → 4 beats accepted, m_axi_r_ready=0 on the 5th; then m1_ready=1 releases the beats in order and ready reasserts next cycle.
- FIFO0 full with m0_ready=0, then beats to RID=6'h21 → master 2 still receives every beat at full rate; master 0 is unaffected.
- Beat RID=6'h3A → accepted, no master valid, route_err=1 next cycle; route_err_clr pulse → 0; clr together with another 6'h3x beat → stays 1.
- FIFO1 holding 1 entry, simultaneous push and pop for 8 cycles → count stays 1, data order is preserved, valid never drops.
- Assert rst_n low mid-burst with 3 beats queued → all valids 0 immediately; after release, the FIFOs are empty and a new beat routes correctly.
